chip8_rom_loader: RTL and testbench

Loads a Chip-8 program image from a byte stream into the CPU's dual-port memory through the read/write port (port A), starting at 0x200. After the last byte it reads the image back and confirms the checksum. It holds the CPU in reset for the whole session. It sits between the host/serial byte source and the memory's port A, which the top level muxes away from the CPU while `cpu_hold` is high.

---
 rtl/chip8_pkg.sv | 16 +
 rtl/chip8_rom_loader.sv | 134 +++++++++++++
 tb/tb_chip8_rom_loader.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared Chip-8 memory constants and ROM loader state type
package chip8_pkg;

   localparam int                MEM_AW    = 12;
   localparam logic [MEM_AW-1:0] PROG_BASE = 12'h200;
   localparam int                MEM_SIZE  = 4096;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      VERIFY,
      DONE,
      ERROR
   } loader_state_e;

endpackage

// File: rtl/chip8_rom_loader.sv
// rtl/chip8_rom_loader.sv - streams a Chip-8 image into memory port A, then reads it back and checks the sum
module chip8_rom_loader
   import chip8_pkg::*;
#(
   parameter logic [MEM_AW-1:0] BASE_ADDR = PROG_BASE,
   parameter int                MAX_LEN   = MEM_SIZE - int'(BASE_ADDR)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic              mem_en,
   output logic              mem_write,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [MEM_AW-1:0] length,
   output logic [7:0]        checksum
);

   localparam logic [MEM_AW-1:0] MAX_LEN_W = MEM_AW'(MAX_LEN);

   loader_state_e     state_q;
   logic [MEM_AW-1:0] length_q, rd_cnt_q, mem_addr_q;
   logic [7:0]        checksum_q, rd_sum_q, mem_wdata_q;
   logic              rd_s1_q;
   logic              mem_en_q, mem_write_q;
   logic              cpu_hold_q, busy_q, done_q, error_q;
   logic              full, accept;

   assign full     = (length_q == MAX_LEN_W);
   assign in_ready = (state_q == LOAD) && !full;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         length_q    <= '0;
         rd_cnt_q    <= '0;
         checksum_q  <= '0;
         rd_sum_q    <= '0;
         rd_s1_q     <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_hold_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         mem_en_q    <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         // Stage 1 marks a read the memory samples this edge; its data is summed on the next edge.
         rd_s1_q     <= mem_en_q && !mem_write_q;
         if (rd_s1_q) begin
            rd_sum_q <= rd_sum_q + mem_rdata;
         end
         case (state_q)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  state_q    <= LOAD;
                  length_q   <= '0;
                  rd_cnt_q   <= '0;
                  checksum_q <= '0;
                  rd_sum_q   <= '0;
                  done_q     <= 1'b0;
                  error_q    <= 1'b0;
                  cpu_hold_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            LOAD: begin
               if (accept) begin
                  mem_en_q    <= 1'b1;
                  mem_write_q <= 1'b1;
                  mem_addr_q  <= BASE_ADDR + length_q;
                  mem_wdata_q <= in_data;
                  length_q    <= length_q + 1'b1;
                  checksum_q  <= checksum_q + in_data;
                  if (in_last) begin
                     state_q <= VERIFY;
                  end
               end else if (in_valid && full) begin
                  state_q    <= ERROR;
                  error_q    <= 1'b1;
                  cpu_hold_q <= 1'b0;
                  busy_q     <= 1'b0;
               end
            end
            VERIFY: begin
               if (rd_cnt_q != length_q) begin
                  mem_en_q   <= 1'b1;
                  mem_addr_q <= BASE_ADDR + rd_cnt_q;
                  rd_cnt_q   <= rd_cnt_q + 1'b1;
               end else if (!mem_en_q && !rd_s1_q) begin
                  // Pipeline drained: the last read-back byte was summed on the previous edge.
                  if (rd_sum_q == checksum_q) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ERROR;
                     error_q <= 1'b1;
                  end
                  cpu_hold_q <= 1'b0;
                  busy_q     <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_hold  = cpu_hold_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign length    = length_q;
   assign checksum  = checksum_q;

endmodule

// File: tb/tb_chip8_rom_loader.sv
// tb/tb_chip8_rom_loader.sv - self-checking bench for chip8_rom_loader with a port-A memory model
module tb_chip8_rom_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n, start0, start1, in_valid, in_last, corrupt_en;
   logic [7:0] in_data;

   logic        in_ready0, mem_en0, mem_write0, cpu_hold0, busy0, done0, error0;
   logic [11:0] mem_addr0, length0;
   logic [7:0]  mem_wdata0, mem_rdata0, checksum0;
   logic        in_ready1, mem_en1, mem_write1, cpu_hold1, busy1, done1, error1;
   logic [11:0] mem_addr1, length1;
   logic [7:0]  mem_wdata1, mem_rdata1, checksum1;

   chip8_rom_loader dut0 (
      .clk(clk), .reset_n(reset_n), .start(start0),
      .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_last(in_last),
      .mem_en(mem_en0), .mem_write(mem_write0), .mem_addr(mem_addr0),
      .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0),
      .cpu_hold(cpu_hold0), .busy(busy0), .done(done0), .error(error0),
      .length(length0), .checksum(checksum0)
   );

   chip8_rom_loader #(.MAX_LEN(4)) dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1),
      .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
      .mem_en(mem_en1), .mem_write(mem_write1), .mem_addr(mem_addr1),
      .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
      .cpu_hold(cpu_hold1), .busy(busy1), .done(done1), .error(error1),
      .length(length1), .checksum(checksum1)
   );

   // Port-A memories: registered read, writes below 0x200 dropped, optional corruption of 0x201.
   logic [7:0]  mem0 [0:4095];
   logic [7:0]  mem1 [0:4095];
   logic [19:0] wlog0 [$];
   logic [19:0] wlog1 [$];

   always @(posedge clk) begin
      if (mem_en0) begin
         if (mem_write0) begin
            wlog0.push_back({mem_addr0, mem_wdata0});
            if (mem_addr0 >= 12'h200)
               mem0[mem_addr0] <= (corrupt_en && mem_addr0 == 12'h201) ? ~mem_wdata0 : mem_wdata0;
         end
         mem_rdata0 <= mem0[mem_addr0];
      end
      if (mem_en1) begin
         if (mem_write1) begin
            wlog1.push_back({mem_addr1, mem_wdata1});
            if (mem_addr1 >= 12'h200) mem1[mem_addr1] <= mem_wdata1;
         end
         mem_rdata1 <= mem1[mem_addr1];
      end
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_in_ready"},  32'(in_ready0),  0);
      chk({tag, "_mem_en"},    32'(mem_en0),    0);
      chk({tag, "_mem_write"}, 32'(mem_write0), 0);
      chk({tag, "_mem_addr"},  32'(mem_addr0),  0);
      chk({tag, "_mem_wdata"}, 32'(mem_wdata0), 0);
      chk({tag, "_cpu_hold"},  32'(cpu_hold0),  0);
      chk({tag, "_busy"},      32'(busy0),      0);
      chk({tag, "_done"},      32'(done0),      0);
      chk({tag, "_error"},     32'(error0),     0);
      chk({tag, "_length"},    32'(length0),    0);
      chk({tag, "_checksum"},  32'(checksum0),  0);
   endtask

   task automatic pulse_start(input bit sel);
      @(negedge clk);
      if (sel) start1 = 1'b1; else start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   // gap_mode 0: continuous, 1: valid toggles every cycle, 2: random gaps. Returns just after the last accepting edge.
   task automatic send(input bit sel, input logic [7:0] img[$], input bit mark_last, input int gap_mode);
      int  i     = 0;
      int  guard = 0;
      bit  tog   = 1'b1;
      bit  take;
      while (i < img.size() && guard < 4000) begin
         @(negedge clk);
         case (gap_mode)
            0:       in_valid = 1'b1;
            1:       begin in_valid = tog; tog = !tog; end
            default: in_valid = ($urandom_range(0, 2) != 0);
         endcase
         in_data = in_valid ? img[i] : 8'($urandom);
         in_last = mark_last && (i == img.size() - 1);
         take    = in_valid && (sel ? in_ready1 : in_ready0);
         @(posedge clk);
         if (take) i++;
         guard++;
      end
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("send_all_accepted", i, img.size());
   endtask

   task automatic run_session(input logic [7:0] img[$], input int gap_mode, input bit corrupt, input string tag);
      int          base;
      int          n;
      bit          hold_ok;
      logic [7:0]  sum;
      logic [19:0] got;
      sum        = 8'h00;
      corrupt_en = corrupt;
      base       = wlog0.size();
      pulse_start(1'b0);
      chk({tag, "_start_hold"},   32'(cpu_hold0),  1);
      chk({tag, "_start_busy"},   32'(busy0),      1);
      chk({tag, "_start_done"},   32'(done0),      0);
      chk({tag, "_start_length"}, 32'(length0),    0);
      chk({tag, "_start_csum"},   32'(checksum0),  0);
      send(1'b0, img, 1'b1, gap_mode);
      foreach (img[j]) sum += img[j];
      chk({tag, "_length"},   32'(length0),   img.size());
      chk({tag, "_checksum"}, 32'(checksum0), 32'(sum));
      n       = 0;
      hold_ok = 1'b1;
      while (n < 200 && !(done0 || error0)) begin
         if (!cpu_hold0) hold_ok = 1'b0;
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"},   n, img.size() + 3);
      chk({tag, "_hold_held"}, 32'(hold_ok),   1);
      chk({tag, "_done"},      32'(done0),     corrupt ? 0 : 1);
      chk({tag, "_error"},     32'(error0),    corrupt ? 1 : 0);
      chk({tag, "_hold_end"},  32'(cpu_hold0), 0);
      chk({tag, "_busy_end"},  32'(busy0),     0);
      chk({tag, "_nwrites"},   wlog0.size() - base, img.size());
      foreach (img[j]) begin
         got = (base + j < wlog0.size()) ? wlog0[base + j] : 20'hFFFFF;
         chk({tag, "_write"}, 32'(got), 32'({12'(12'h200 + j), img[j]}));
         if (!corrupt) chk({tag, "_mem"}, 32'(mem0[12'h200 + j]), 32'(img[j]));
      end
   endtask

   logic [7:0] img [$];
   logic [7:0] sum_m;
   int         base1;

   initial begin
      reset_n    = 1'b0;
      start0     = 1'b0;
      start1     = 1'b0;
      in_valid   = 1'b0;
      in_last    = 1'b0;
      in_data    = 8'h00;
      corrupt_en = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      reset_n = 1'b1;

      img = '{8'hA2, 8'h0F, 8'h60, 8'h05};
      run_session(img, 0, 1'b0, "basic");
      chk("basic_csum_const", 32'(checksum0), 32'h16);

      img = '{8'hFF};
      run_session(img, 0, 1'b0, "one_byte");

      img.delete();
      for (int j = 0; j < 16; j++) img.push_back(8'($urandom));
      run_session(img, 1, 1'b0, "backpressure");

      for (int s = 0; s < 3; s++) begin
         img.delete();
         for (int j = 0; j < int'($urandom_range(1, 40)); j++) img.push_back(8'($urandom));
         run_session(img, 2, 1'b0, "random");
      end

      img.delete();
      for (int j = 0; j < 4; j++) img.push_back(8'($urandom));
      run_session(img, 0, 1'b1, "mismatch");
      corrupt_en = 1'b0;

      // Overflow on the 4-byte instance: fifth byte must be refused and nothing written for it.
      base1 = wlog1.size();
      pulse_start(1'b1);
      img = '{8'h11, 8'h22, 8'h33, 8'h44};
      send(1'b1, img, 1'b0, 0);
      chk("ovf_length", 32'(length1), 4);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hEE;
      in_last  = 1'b0;
      chk("ovf_ready_low", 32'(in_ready1), 0);
      @(negedge clk);
      chk("ovf_error", 32'(error1),    1);
      chk("ovf_done",  32'(done1),     0);
      chk("ovf_hold",  32'(cpu_hold1), 0);
      chk("ovf_len",   32'(length1),   4);
      in_valid = 1'b0;
      @(negedge clk);
      chk("ovf_nwrites", wlog1.size() - base1, 4);
      chk("ovf_last_addr", 32'(wlog1[wlog1.size() - 1][19:8]), 32'h203);

      // start mid-LOAD is ignored, then reset mid-LOAD returns everything to idle.
      pulse_start(1'b0);
      img = '{8'h01, 8'h02, 8'h03};
      send(1'b0, img, 1'b0, 2);
      chk("midload_len3", 32'(length0), 3);
      pulse_start(1'b0);
      chk("midstart_len",   32'(length0),   3);
      chk("midstart_busy",  32'(busy0),     1);
      chk("midstart_ready", 32'(in_ready0), 1);
      img = '{8'h40, 8'hC0};
      send(1'b0, img, 1'b0, 0);
      sum_m = 8'h01 + 8'h02 + 8'h03 + 8'h40 + 8'hC0;
      chk("midload_len5",  32'(length0),   5);
      chk("midload_csum",  32'(checksum0), 32'(sum_m));
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk_reset("midreset");
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_reset_ready", 32'(in_ready0), 0);
      chk("post_reset_busy",  32'(busy0),     0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
